// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the UART FIFO buffer: default widths and the status flag bundle.
package uart_fifo_pkg;

  parameter int unsigned DefaultAddrWidth = 3;
  parameter int unsigned DefaultDataWidth = 8;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

  localparam fifo_flags_t FlagsReset = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1,
    overflow:     1'b0,
    underflow:    1'b0
  };

endpackage

// File: rtl/fifo_mem.sv
// Dual-port storage array: synchronous write, asynchronous read, no reset.
module fifo_mem #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo_buffer.sv
// Show-ahead FIFO with registered status flags and sticky overflow/underflow errors.
module uart_fifo_buffer
  import uart_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned AF_LEVEL   = (2**ADDR_WIDTH) - 1,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0]   DepthCnt = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AfCnt    = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AeCnt    = AE_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CntOne   = 1;
  localparam logic [ADDR_WIDTH-1:0] PtrOne   = 1;

  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
    $error("uart_fifo_buffer: requires AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  fifo_flags_t           flags_q, flags_d;
  logic                  push, pop, ovf_err, udf_err;

  // A full FIFO still accepts a push when a pop frees the head slot on the same edge.
  assign push    = wr && (!flags_q.full || rd);
  assign pop     = rd && !flags_q.empty;
  assign ovf_err = wr && flags_q.full && !rd;
  assign udf_err = rd && flags_q.empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    flags_d  = FlagsReset;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      if (push && !pop)      count_d = count_q + CntOne;
      else if (pop && !push) count_d = count_q - CntOne;
      // A new error wins over a simultaneous clear.
      flags_d.overflow  = (flags_q.overflow && !clr_err) || ovf_err;
      flags_d.underflow = (flags_q.underflow && !clr_err) || udf_err;
    end
    flags_d.full         = (count_d == DepthCnt);
    flags_d.empty        = (count_d == '0);
    flags_d.almost_full  = (count_d >= AfCnt);
    flags_d.almost_empty = (count_d <= AeCnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= FlagsReset;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
    end
  end

  fifo_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (push && !flush && !reset),
    .waddr(wr_ptr_q),
    .wdata(w_data),
    .raddr(rd_ptr_q),
    .rdata(r_data)
  );

  assign count        = count_q;
  assign full         = flags_q.full;
  assign empty        = flags_q.empty;
  assign almost_full  = flags_q.almost_full;
  assign almost_empty = flags_q.almost_empty;
  assign overflow     = flags_q.overflow;
  assign underflow    = flags_q.underflow;

endmodule

// File: tb/tb_uart_fifo_buffer.sv
// Directed bench for uart_fifo_buffer at default parameters (DEPTH=8, AF=7, AE=1).
module tb_uart_fifo_buffer;

  logic       clk = 1'b0;
  logic       reset, wr, rd, flush, clr_err;
  logic [7:0] w_data, r_data;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  int checks   = 0;
  int failures = 0;

  uart_fifo_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .w_data      (w_data),
    .rd          (rd),
    .r_data      (r_data),
    .flush       (flush),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  // Inputs applied for one edge, then sampled 1ns after it; inputs return to idle.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    wr = w; rd = r; w_data = d;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0; reset = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; step(1'b0, 1'b0, 8'h00);
    reset = 1'b1; step(1'b0, 1'b0, 8'h00);
    chk("reset_count", {4'h0, count}, 8'h00);
    chk("reset_empty", {7'h0, empty}, 8'h01);
    chk("reset_ae", {7'h0, almost_empty}, 8'h01);
    chk("reset_full", {7'h0, full}, 8'h00);
    chk("reset_af", {7'h0, almost_full}, 8'h00);
    chk("reset_ovf", {7'h0, overflow}, 8'h00);
    chk("reset_udf", {7'h0, underflow}, 8'h00);
  endtask

  task automatic test_basic();
    step(1'b1, 1'b0, 8'h11);
    chk("basic_first_show_ahead", r_data, 8'h11);
    chk("basic_ae_at_1", {7'h0, almost_empty}, 8'h01);
    step(1'b1, 1'b0, 8'h22);
    chk("basic_ae_at_2", {7'h0, almost_empty}, 8'h00);
    step(1'b1, 1'b0, 8'h33);
    chk("basic_count3", {4'h0, count}, 8'h03);
    chk("basic_head", r_data, 8'h11);
    step(1'b0, 1'b1, 8'h00);
    chk("basic_pop1", r_data, 8'h22);
    step(1'b0, 1'b1, 8'h00);
    chk("basic_pop2", r_data, 8'h33);
    step(1'b0, 1'b1, 8'h00);
    chk("basic_empty", {7'h0, empty}, 8'h01);
    chk("basic_count0", {4'h0, count}, 8'h00);
    chk("basic_no_udf", {7'h0, underflow}, 8'h00);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'h80 + 8'(i));
      if (i == 6) begin
        chk("fill_count7", {4'h0, count}, 8'h07);
        chk("fill_af_at_7", {7'h0, almost_full}, 8'h01);
        chk("fill_not_full_at_7", {7'h0, full}, 8'h00);
      end
    end
    chk("fill_full", {7'h0, full}, 8'h01);
    chk("fill_count8", {4'h0, count}, 8'h08);
    step(1'b1, 1'b0, 8'hFF);
    chk("fill_ovf", {7'h0, overflow}, 8'h01);
    chk("fill_ovf_count", {4'h0, count}, 8'h08);
    chk("fill_ovf_head", r_data, 8'h80);
    step(1'b0, 1'b0, 8'h00);
    chk("fill_ovf_sticky", {7'h0, overflow}, 8'h01);
    clr_err = 1'b1; step(1'b0, 1'b0, 8'h00);
    chk("fill_ovf_cleared", {7'h0, overflow}, 8'h00);
  endtask

  task automatic test_full_rw();
    logic [7:0] exp [8];
    step(1'b1, 1'b1, 8'hA5);
    chk("fullrw_count", {4'h0, count}, 8'h08);
    chk("fullrw_full", {7'h0, full}, 8'h01);
    chk("fullrw_no_ovf", {7'h0, overflow}, 8'h00);
    for (int i = 0; i < 7; i++) exp[i] = 8'h81 + 8'(i);
    exp[7] = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fullrw_pop%0d", i), r_data, exp[i]);
      step(1'b0, 1'b1, 8'h00);
    end
    chk("fullrw_empty", {7'h0, empty}, 8'h01);
  endtask

  task automatic test_empty_rw();
    step(1'b1, 1'b1, 8'h5A);
    chk("emptyrw_count", {4'h0, count}, 8'h01);
    chk("emptyrw_data", r_data, 8'h5A);
    chk("emptyrw_udf", {7'h0, underflow}, 8'h01);
    clr_err = 1'b1; step(1'b0, 1'b0, 8'h00);
    chk("emptyrw_udf_clr", {7'h0, underflow}, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    // Fresh underflow in the same cycle as clr_err must stay set.
    clr_err = 1'b1; step(1'b0, 1'b1, 8'h00);
    chk("udf_beats_clr", {7'h0, underflow}, 8'h01);
    chk("udf_count", {4'h0, count}, 8'h00);
    clr_err = 1'b1; step(1'b0, 1'b0, 8'h00);
    chk("udf_clr2", {7'h0, underflow}, 8'h00);
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 8'h40);
    for (int i = 1; i < 20; i++) begin
      chk($sformatf("stream_head%0d", i - 1), r_data, 8'h40 + 8'(i - 1));
      step(1'b1, 1'b1, 8'h40 + 8'(i));
      chk($sformatf("stream_count%0d", i), {4'h0, count}, 8'h01);
    end
    chk("stream_last", r_data, 8'h53);
    step(1'b0, 1'b1, 8'h00);
    chk("stream_empty", {7'h0, empty}, 8'h01);
    chk("stream_no_err", {6'h0, overflow, underflow}, 8'h00);
  endtask

  task automatic test_flush();
    step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h60 + 8'(i));
    chk("flush_pre_count", {4'h0, count}, 8'h05);
    chk("flush_pre_udf", {7'h0, underflow}, 8'h01);
    flush = 1'b1; step(1'b1, 1'b0, 8'hEE);
    chk("flush_count", {4'h0, count}, 8'h00);
    chk("flush_flags", {2'b00, full, empty, almost_full, almost_empty, overflow, underflow},
        8'b0001_0100);
    step(1'b1, 1'b0, 8'h77);
    chk("flush_then_push", r_data, 8'h77);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 8'h99);
    reset = 1'b1; step(1'b1, 1'b0, 8'hAA);
    chk("midreset_count", {4'h0, count}, 8'h00);
    chk("midreset_empty", {7'h0, empty}, 8'h01);
    step(1'b1, 1'b0, 8'h3C);
    chk("midreset_head", r_data, 8'h3C);
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0; w_data = '0;
    test_reset();
    test_basic();
    test_fill();
    test_full_rw();
    test_empty_rw();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_fifo_buffer.md
UART_FIFO_BUFFER -- requirements
Module: uart_fifo_buffer

Interface
REQ-001 Parameter ADDR_WIDTH, default 3, pointer width; depth DEPTH = 2**ADDR_WIDTH entries SHALL be derived.
REQ-002 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-003 Parameter AF_LEVEL, default DEPTH-1, occupancy at or above which almost_full SHALL assert.
REQ-004 Parameter AE_LEVEL, default 1, occupancy at or below which almost_empty SHALL assert.
REQ-005 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 wr  input  1  push request.
REQ-009 w_data  input  DATA_WIDTH  word to push.
REQ-010 rd  input  1  pop request.
REQ-011 r_data  output  DATA_WIDTH  head word, show-ahead (valid whenever empty=0).
REQ-012 flush  input  1  synchronous clear of contents, pointers and count.
REQ-013 full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-015 overflow, underflow  output  1 each  sticky error flags.
REQ-016 clr_err  input  1  clears overflow and underflow.

Function
REQ-017 Push SHALL be accepted when wr=1 and (full=0 or rd=1); word SHALL be written at wr_ptr, wr_ptr SHALL increment modulo DEPTH.
REQ-018 Pop SHALL be accepted when rd=1 and empty=0; rd_ptr SHALL increment modulo DEPTH.
REQ-019 r_data SHALL equal storage[rd_ptr] combinationally; a pushed word SHALL appear on r_data the cycle after the push when FIFO was empty.
REQ-020 count SHALL update on the same edge: +1 push only, -1 pop only, unchanged both or neither.
REQ-021 Full with wr=1, rd=1: both accepted, count stays DEPTH, full stays 1.
REQ-022 Empty with wr=1, rd=1: push accepted, pop rejected, count becomes 1, underflow set.
REQ-023 wr=1 while full and rd=0: push dropped, contents unchanged, overflow set.
REQ-024 rd=1 while empty: pointers unchanged, underflow set.
REQ-025 overflow/underflow SHALL remain 1 until clr_err=1 or reset/flush; clr_err and a new error in same cycle: error flag SHALL be 1.
REQ-026 Flags SHALL be registered, derived from next-state count: full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL), almost_empty=(count<=AE_LEVEL).
REQ-027 Pointer wrap from DEPTH-1 to 0 SHALL not disturb count or flags.
REQ-028 flush SHALL take priority over wr/rd in the same cycle; storage contents need not be cleared.

Reset
REQ-029 On reset=1 at a rising edge: wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-030 Reset mid-operation SHALL discard all stored words; r_data is don't-care while empty=1.
REQ-031 Storage array SHALL not be reset.

Structure
REQ-032 Shared package uart_fifo_pkg SHALL hold default ADDR_WIDTH/DATA_WIDTH constants and the flag-bundle struct type.
REQ-033 Storage SHALL be a sub-module fifo_mem (parametrised dual-port array, synchronous write, asynchronous read); pointer/count/flag logic in uart_fifo_buffer.
REQ-034 Parameter legality (AE_LEVEL < AF_LEVEL <= DEPTH) SHALL be checked at elaboration.

Verification
REQ-035 Reset, then push 0x11,0x22,0x33 -> count=3, r_data=0x11; three pops -> r_data 0x22,0x33, empty=1.
REQ-036 Defaults (DEPTH=8): push 8 words -> full=1 after 8th edge, almost_full=1 at count 7; 9th push -> overflow=1, contents unchanged.
REQ-037 Full, wr=rd=1 with 0xA5 -> count stays 8, 0xA5 read out 8 pops later.
REQ-038 Empty, wr=rd=1 with 0x5A -> count=1, r_data=0x5A, underflow=1; clr_err -> underflow=0.
REQ-039 Push/pop 20 words continuously -> pointers wrap twice, data order preserved, no error flags.
REQ-040 count=5 then flush=1 with wr=1 -> count=0, empty=1, flags as reset.
